// File: rtl/im_loader.sv
// Byte-stream to instruction-memory loader: packs big-endian bytes into 32-bit words and writes them sequentially.
// Optional CHECKSUM output (XOR of all written words) is enabled with `define IM_LOADER_CHECKSUM_EN.
module im_loader #(
    parameter int ADDR_W = 10,
    parameter int DIM    = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic              we,
    output logic [ADDR_W-1:0] address,
    output logic [31:0]       data,
    output logic              busy,
    output logic              done,
`ifdef IM_LOADER_CHECKSUM_EN
    output logic              error,
    output logic [31:0]       checksum
`else
    output logic              error
`endif
);

    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, FINISH} state_t;

    localparam logic [ADDR_W:0]   DIM_L    = DIM[ADDR_W:0];
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t          state;
    logic [ADDR_W:0] len;
    logic [1:0]      byte_cnt;
    logic            legal_start;

    assign legal_start = (state == IDLE) && start && (length != '0) && (length <= DIM_L);

    // Outputs are registered alongside the state so each one is a clean function of the current state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            len        <= '0;
            byte_cnt   <= '0;
            byte_ready <= 1'b0;
            we         <= 1'b0;
            address    <= '0;
            data       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (length == '0) begin
                            state <= FINISH;
                            busy  <= 1'b1;
                            done  <= 1'b1;
                        end else if (length > DIM_L) begin
                            error <= 1'b1;
                        end else begin
                            state      <= COLLECT;
                            len        <= length;
                            address    <= '0;
                            byte_cnt   <= '0;
                            error      <= 1'b0;
                            busy       <= 1'b1;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (byte_valid) begin
                        data     <= {data[23:0], byte_in};
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state      <= WRITE;
                            byte_ready <= 1'b0;
                            we         <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    we <= 1'b0;
                    // address holds the index of the word just written, so address+1 is the words-written count
                    if (({1'b0, address} + LEN_ONE) == len) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state      <= COLLECT;
                        address    <= address + ADDR_ONE;
                        byte_ready <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (legal_start) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum ^ data;
        end
    end
`endif

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: a scoreboard of expected {address, data} writes is checked on every WE.
`timescale 1ns/1ps
module tb_im_loader;
    localparam int ADDR_W = 10;
    localparam int DIM    = 1024;
    typedef logic [ADDR_W+31:0] wr_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   length = '0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready, we, busy, done, error;
    logic [ADDR_W-1:0] address;
    logic [31:0]       data;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0]       checksum;
`endif

    int  total = 0, passed = 0;
    int  cyc = 0, we_cnt = 0, done_cnt = 0, max_addr = 0, acc_cyc = 0;
    wr_t exp_q[$];

    im_loader #(.ADDR_W(ADDR_W), .DIM(DIM)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .length(length),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .we(we), .address(address), .data(data), .busy(busy), .done(done),
`ifdef IM_LOADER_CHECKSUM_EN
        .error(error), .checksum(checksum)
`else
        .error(error)
`endif
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write monitor: every WE must match the head of the scoreboard.
    initial forever begin
        @(negedge clk);
        if (rst_n && we) begin
            wr_t e;
            we_cnt++;
            if (int'(address) > max_addr) max_addr = int'(address);
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_we: got addr=%0d data=%h, expected no write", address, data);
            end else begin
                e = exp_q.pop_front();
                if ({address, data} !== e)
                    $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             address, data, e[ADDR_W+31:32], e[31:0]);
                else passed++;
            end
            total++;
            if (byte_ready !== 1'b0) $display("FAIL ready_in_write: got %b, expected 0", byte_ready);
            else passed++;
        end
        if (rst_n && done) done_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [ADDR_W:0] len);
        @(posedge clk); #1;
        start = 1'b1;
        length = len;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (byte_ready) begin
                acc_cyc = cyc;
                @(posedge clk); #1;
                byte_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        total++;
        $display("FAIL byte_accept: byte %h not accepted within 50 cycles", b);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_byte(w[31-8*j -: 8]);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({we, byte_ready, busy, done, error} !== 5'b0)
            $display("FAIL reset_flags: got we,rdy,busy,done,err=%b, expected 00000", {we, byte_ready, busy, done, error});
        else passed++;
        total++;
        if (address !== '0) $display("FAIL reset_address: got %0d, expected 0", address); else passed++;
        total++;
        if (data !== 32'h0) $display("FAIL reset_data: got %h, expected 0", data); else passed++;
`ifdef IM_LOADER_CHECKSUM_EN
        total++;
        if (checksum !== 32'h0) $display("FAIL reset_checksum: got %h, expected 0", checksum); else passed++;
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_illegal_length();
        int wc = we_cnt;
        do_start(11'd1025);
        @(negedge clk);
        total++;
        if (error !== 1'b1) $display("FAIL illegal_error: got %b, expected 1", error); else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL illegal_busy: got %b, expected 0", busy); else passed++;
        repeat (5) @(negedge clk);
        total++;
        if (we_cnt !== wc) $display("FAIL illegal_no_we: got %0d writes, expected 0", we_cnt - wc); else passed++;
    endtask

    task automatic test_two_words();
        int wc = we_cnt, dc = done_cnt, first_acc;
        bit ok;
        exp_q.push_back({10'd0, 32'h12345678});
        exp_q.push_back({10'd1, 32'h9ABCDEF0});
        do_start(11'd2);
        send_byte(8'h12);
        first_acc = acc_cyc;
        send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
        total++;
        if ({busy, error} !== 2'b10) $display("FAIL two_busy_err: got %b, expected 10", {busy, error}); else passed++;
        send_word(32'h9ABCDEF0);
        wait_done(20, ok);
        total++;
        if (!ok) $display("FAIL two_done: got no DONE, expected DONE within 20 cycles"); else passed++;
        total++;
        if (cyc - first_acc !== 10) $display("FAIL two_latency: got %0d cycles, expected 10", cyc - first_acc); else passed++;
        total++;
        if ({address, data} !== {10'd1, 32'h9ABCDEF0})
            $display("FAIL two_hold: got addr=%0d data=%h, expected 1 9abcdef0", address, data);
        else passed++;
`ifdef IM_LOADER_CHECKSUM_EN
        total++;
        if (checksum !== 32'h88888888) $display("FAIL checksum: got %h, expected 88888888", checksum); else passed++;
`endif
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL two_idle: got done,busy=%b, expected 00", {done, busy}); else passed++;
        total++;
        if (we_cnt - wc !== 2 || done_cnt - dc !== 1 || exp_q.size() !== 0)
            $display("FAIL two_counts: got we=%0d done=%0d pending=%0d, expected 2 1 0", we_cnt - wc, done_cnt - dc, exp_q.size());
        else passed++;
    endtask

    task automatic test_gapped();
        int wc = we_cnt;
        bit ok;
        logic [31:0] w = 32'h11223344;
        exp_q.push_back({10'd0, w});
        do_start(11'd1);
        for (int j = 0; j < 4; j++) begin
            send_byte(w[31-8*j -: 8]);
            if (j < 3) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    total++;
                    if (byte_ready !== 1'b1) $display("FAIL gap_ready: got %b, expected 1", byte_ready); else passed++;
                    @(posedge clk); #1;
                end
            end
        end
        wait_done(10, ok);
        total++;
        if (!ok || we_cnt - wc !== 1 || exp_q.size() !== 0)
            $display("FAIL gapped: got done=%b writes=%0d pending=%0d, expected 1 1 0", ok, we_cnt - wc, exp_q.size());
        else passed++;
    endtask

    task automatic test_zero_length();
        int wc = we_cnt;
        do_start(11'd0);
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b11) $display("FAIL zero_done: got done,busy=%b, expected 11", {done, busy}); else passed++;
        @(negedge clk);
        total++;
        if ({done, busy} !== 2'b00) $display("FAIL zero_end: got done,busy=%b, expected 00", {done, busy}); else passed++;
        total++;
        if (we_cnt !== wc) $display("FAIL zero_no_we: got %0d writes, expected 0", we_cnt - wc); else passed++;
    endtask

    task automatic test_reset_mid_load();
        int wc = we_cnt;
        bit ok;
        exp_q.push_back({10'd0, 32'hA1A2A3A4});
        exp_q.push_back({10'd1, 32'hB1B2B3B4});
        do_start(11'd4);
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        send_byte(8'hC1);
        send_byte(8'hC2);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({we, byte_ready, busy, done, error} !== 5'b0 || address !== '0 || data !== 32'h0)
            $display("FAIL async_reset: got flags=%b addr=%0d data=%h, expected all 0",
                     {we, byte_ready, busy, done, error}, address, data);
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (we_cnt - wc !== 2 || exp_q.size() !== 0)
            $display("FAIL reset_abandon: got writes=%0d pending=%0d, expected 2 0", we_cnt - wc, exp_q.size());
        else passed++;
        exp_q.push_back({10'd0, 32'hCAFEF00D});
        do_start(11'd1);
        send_word(32'hCAFEF00D);
        wait_done(10, ok);
        total++;
        if (!ok || we_cnt - wc !== 3 || address !== '0)
            $display("FAIL reload: got done=%b writes=%0d addr=%0d, expected 1 3 0", ok, we_cnt - wc, address);
        else passed++;
    endtask

    task automatic test_full_depth();
        int wc = we_cnt, dc = done_cnt;
        bit ok;
        logic [31:0] w;
        max_addr = 0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < 4; j++) w[31-8*j -: 8] = 8'((i * 4 + j) & 255);
            exp_q.push_back({10'(i), w});
        end
        fork
            begin
                repeat (2000) @(posedge clk);
                #1 start = 1'b1;
                length = 11'd3;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join_none
        do_start(11'd1024);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < 4; j++) send_byte(8'((i * 4 + j) & 255));
        wait_done(10, ok);
        total++;
        if (!ok) $display("FAIL full_done: got no DONE, expected DONE after word 1023"); else passed++;
        total++;
        if (max_addr !== DIM - 1 || address !== 10'd1023)
            $display("FAIL full_addr: got max=%0d final=%0d, expected 1023 1023", max_addr, address);
        else passed++;
        @(negedge clk);
        total++;
        if (we_cnt - wc !== DIM || done_cnt - dc !== 1 || exp_q.size() !== 0)
            $display("FAIL full_counts: got writes=%0d done=%0d pending=%0d, expected 1024 1 0",
                     we_cnt - wc, done_cnt - dc, exp_q.size());
        else passed++;
    endtask

    initial begin
        test_reset();
        test_illegal_length();
        test_two_words();
        test_gapped();
        test_zero_length();
        test_reset_mid_load();
        test_full_depth();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
